// File: rtl/mage_pkg.sv
// Purpose: shared parameters and state type for the MAGE hardware-loop IV generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mage_pkg;

    localparam int N_LP       = 4;  // loop nest depth, level 0 innermost
    localparam int NBIT_LP_IV = 8;  // unsigned induction-variable width
    localparam int NBIT_II    = 4;  // initiation-interval counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hwlp_state_t;

endpackage

// File: rtl/hwlp_iv_gen_if.sv
// Purpose: groups the loop configuration, control and IV tuple outputs of hwlp_iv_gen.
// Latency: n/a (wiring only).
// Backpressure: stall_i freezes iteration progress; start_i low aborts.
// Ports: master drives control/config and observes the tuple; slave is the generator.
interface hwlp_iv_gen_if #(
    parameter int N_LP       = mage_pkg::N_LP,
    parameter int NBIT_LP_IV = mage_pkg::NBIT_LP_IV,
    parameter int NBIT_II    = mage_pkg::NBIT_II
);
    localparam int NBIT_NLP = $clog2(N_LP) + 1;

    logic                                 start_i;
    logic                                 stall_i;
    logic [NBIT_NLP-1:0]                  n_lp_i;
    logic [N_LP-1:0][NBIT_LP_IV-1:0]      lp_start_i;
    logic [N_LP-1:0][NBIT_LP_IV-1:0]      lp_end_i;
    logic [N_LP-1:0][NBIT_LP_IV-1:0]      lp_stride_i;
    logic [NBIT_II-1:0]                   ii_i;
    logic                                 hwlp_valid_o;
    logic [N_LP-1:0][NBIT_LP_IV-1:0]      loop_vars_o;
    logic [N_LP-1:0]                      end_condition_lp_o;
    logic                                 end_lp_o;
    logic                                 busy_o;
    logic                                 done_o;

    modport master (
        output start_i, stall_i, n_lp_i, lp_start_i, lp_end_i, lp_stride_i, ii_i,
        input  hwlp_valid_o, loop_vars_o, end_condition_lp_o, end_lp_o, busy_o, done_o
    );

    modport slave (
        input  start_i, stall_i, n_lp_i, lp_start_i, lp_end_i, lp_stride_i, ii_i,
        output hwlp_valid_o, loop_vars_o, end_condition_lp_o, end_lp_o, busy_o, done_o
    );

endinterface

// File: rtl/hwlp_level_cnt.sv
// Purpose: one odometer digit of the loop nest: holds a level IV and flags its last value.
// Latency: IV updates one cycle after load/advance; end_condition/carry_out are combinational.
// Backpressure: none locally; the parent withholds advance while stalled or pacing.
// Ports: clear/load/load_val set the IV, advance+carry_in step it, start/end_val/stride/active
//        describe the level; iv, end_condition, carry_out report it.
module hwlp_level_cnt #(
    parameter int NBIT_LP_IV = mage_pkg::NBIT_LP_IV
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear,
    input  logic                  load,
    input  logic [NBIT_LP_IV-1:0] load_val,
    input  logic                  advance,
    input  logic                  carry_in,
    input  logic [NBIT_LP_IV-1:0] start,
    input  logic [NBIT_LP_IV-1:0] end_val,
    input  logic [NBIT_LP_IV-1:0] stride,
    input  logic                  active,
    output logic [NBIT_LP_IV-1:0] iv,
    output logic                  end_condition,
    output logic                  carry_out
);
    logic [NBIT_LP_IV-1:0] iv_q;
    logic [NBIT_LP_IV:0]   iv_next_wide;

    // One extra bit so iv+stride never wraps below the bound.
    assign iv_next_wide  = {1'b0, iv_q} + {1'b0, stride};
    assign end_condition = active ? (iv_next_wide >= {1'b0, end_val}) : 1'b1;
    assign carry_out     = carry_in & end_condition;
    assign iv            = iv_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            iv_q <= '0;
        end else if (clear) begin
            iv_q <= '0;
        end else if (load) begin
            iv_q <= load_val;
        end else if (advance && carry_in && active) begin
            // Wrap to start and let the carry ripple outward, else step.
            iv_q <= end_condition ? start : iv_next_wide[NBIT_LP_IV-1:0];
        end
    end

endmodule

// File: rtl/hwlp_iv_gen.sv
// Purpose: walks a configured loop nest and emits one IV tuple per issued iteration.
// Latency: first valid one cycle after start_i rises; then one issue every ii cycles.
// Backpressure: stall_i freezes IVs and the ii counter; start_i low aborts to IDLE.
// Ports: clk_i, rst_n_i (async active-low), bus (hwlp_iv_gen_if.slave: config, control, tuple).
module hwlp_iv_gen
    import mage_pkg::*;
#(
    parameter int N_LP       = mage_pkg::N_LP,
    parameter int NBIT_LP_IV = mage_pkg::NBIT_LP_IV,
    parameter int NBIT_II    = mage_pkg::NBIT_II
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    hwlp_iv_gen_if.slave  bus
);
    localparam int NBIT_NLP = $clog2(N_LP) + 1;

    hwlp_state_t                     state_q, state_d;
    logic [NBIT_NLP-1:0]             n_lp_q;
    logic [N_LP-1:0][NBIT_LP_IV-1:0] start_q, end_q, stride_q;
    logic [NBIT_II-1:0]              ii_q, ii_cnt_q;

    logic                            capture, clear, issue, advance, all_end, empty_in;
    logic [N_LP-1:0]                 active_in, active_q, end_cond;
    logic [N_LP:0]                   carry;
    logic [N_LP-1:0][NBIT_LP_IV-1:0] load_val, iv_w;

    assign capture = (state_q == IDLE) && bus.start_i;
    assign clear   = !bus.start_i;

    always_comb begin
        empty_in  = 1'b0;
        active_in = '0;
        active_q  = '0;
        load_val  = '0;
        for (int k = 0; k < N_LP; k++) begin
            active_in[k] = NBIT_NLP'(k) < bus.n_lp_i;
            active_q[k]  = NBIT_NLP'(k) < n_lp_q;
            load_val[k]  = active_in[k] ? bus.lp_start_i[k] : '0;
            if (active_in[k] && (bus.lp_start_i[k] >= bus.lp_end_i[k]))
                empty_in = 1'b1;
        end
    end

    // Level 0 always receives a carry; carry out of the top level means the nest is done.
    assign carry[0] = 1'b1;
    assign all_end  = carry[N_LP];
    assign issue    = (state_q == RUN) && bus.start_i && !bus.stall_i && (ii_cnt_q == '0);
    // The final issue leaves IVs at their last values instead of wrapping the whole nest.
    assign advance  = issue && !all_end;

    for (genvar k = 0; k < N_LP; k++) begin : g_lvl
        hwlp_level_cnt #(.NBIT_LP_IV(NBIT_LP_IV)) u_lvl (
            .clk_i         (clk_i),
            .rst_n_i       (rst_n_i),
            .clear         (clear),
            .load          (capture),
            .load_val      (load_val[k]),
            .advance       (advance),
            .carry_in      (carry[k]),
            .start         (start_q[k]),
            .end_val       (end_q[k]),
            .stride        (stride_q[k]),
            .active        (active_q[k]),
            .iv            (iv_w[k]),
            .end_condition (end_cond[k]),
            .carry_out     (carry[k+1])
        );
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = empty_in ? DONE : RUN;
            RUN:     if (!bus.start_i) state_d = IDLE;
                     else if (issue && all_end) state_d = DONE;
            DONE:    if (!bus.start_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Zero stride and zero ii are normalised to 1 once, at capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i || clear) begin
            n_lp_q   <= '0;
            start_q  <= '0;
            end_q    <= '0;
            stride_q <= '0;
            ii_q     <= '0;
        end else if (capture) begin
            n_lp_q  <= bus.n_lp_i;
            start_q <= bus.lp_start_i;
            end_q   <= bus.lp_end_i;
            for (int k = 0; k < N_LP; k++)
                stride_q[k] <= (bus.lp_stride_i[k] == '0) ? NBIT_LP_IV'(1) : bus.lp_stride_i[k];
            ii_q <= (bus.ii_i == '0) ? NBIT_II'(1) : bus.ii_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                           ii_cnt_q <= '0;
        else if (clear)                         ii_cnt_q <= '0;
        else if (issue)                         ii_cnt_q <= ii_q - NBIT_II'(1);
        else if (ii_cnt_q != '0 && !bus.stall_i) ii_cnt_q <= ii_cnt_q - NBIT_II'(1);
    end

    assign bus.hwlp_valid_o       = issue;
    assign bus.end_lp_o           = issue && all_end;
    assign bus.loop_vars_o        = iv_w;
    assign bus.end_condition_lp_o = end_cond;
    assign bus.busy_o             = (state_q == RUN);
    assign bus.done_o             = (state_q == DONE);

endmodule

// File: tb/tb_hwlp_iv_gen.sv
module tb_hwlp_iv_gen;
    localparam int NL = 4;
    localparam int NB = 8;
    localparam int NI = 4;
    localparam int NC = 32;

    logic clk_i;
    logic rst_n_i;
    int   n_pass;
    int   n_total;

    hwlp_iv_gen_if #(.N_LP(NL), .NBIT_LP_IV(NB), .NBIT_II(NI)) bus ();

    hwlp_iv_gen #(.N_LP(NL), .NBIT_LP_IV(NB), .NBIT_II(NI)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Per-cycle record of the outputs; cycle 0 is the cycle start_i rises.
    logic                v_rec    [NC];
    logic                el_rec   [NC];
    logic                done_rec [NC];
    logic                busy_rec [NC];
    logic [NL-1:0]       ec_rec   [NC];
    logic [NL-1:0][NB-1:0] lv_rec [NC];

    task automatic set_cfg(input int n, input int s0, input int e0, input int st0,
                           input int s1, input int e1, input int st1, input int ii);
        bus.n_lp_i         = 3'(n);
        bus.lp_start_i[0]  = 8'(s0);  bus.lp_end_i[0] = 8'(e0);  bus.lp_stride_i[0] = 8'(st0);
        bus.lp_start_i[1]  = 8'(s1);  bus.lp_end_i[1] = 8'(e1);  bus.lp_stride_i[1] = 8'(st1);
        // Upper levels carry non-zero config that must be ignored while inactive.
        bus.lp_start_i[2]  = 8'd5;    bus.lp_end_i[2] = 8'd9;    bus.lp_stride_i[2] = 8'd1;
        bus.lp_start_i[3]  = 8'd7;    bus.lp_end_i[3] = 8'd8;    bus.lp_stride_i[3] = 8'd1;
        bus.ii_i           = 4'(ii);
    endtask

    // Entered and left just after a rising edge.
    task automatic run_seq(input int ncyc, input int st_lo, input int st_hi, input int drop_c);
        for (int c = 0; c < ncyc; c++) begin
            bus.start_i = !(drop_c >= 0 && c >= drop_c);
            bus.stall_i = (c >= st_lo && c <= st_hi);
            @(negedge clk_i);
            v_rec[c]    = bus.hwlp_valid_o;
            el_rec[c]   = bus.end_lp_o;
            done_rec[c] = bus.done_o;
            busy_rec[c] = bus.busy_o;
            ec_rec[c]   = bus.end_condition_lp_o;
            lv_rec[c]   = bus.loop_vars_o;
            @(posedge clk_i); #1;
        end
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        repeat (2) begin @(posedge clk_i); #1; end
    endtask

    task automatic test_reset;
        n_total++;
        if ({bus.hwlp_valid_o, bus.end_lp_o, bus.busy_o, bus.done_o} !== 4'b0000) begin
            $display("FAIL reset_ctrl: got %b want 0000",
                     {bus.hwlp_valid_o, bus.end_lp_o, bus.busy_o, bus.done_o});
        end else n_pass++;
        n_total++;
        if (bus.loop_vars_o !== 32'h0) $display("FAIL reset_ivs: got %h want 0", bus.loop_vars_o);
        else n_pass++;
        n_total++;
        if (bus.end_condition_lp_o !== 4'hF)
            $display("FAIL reset_ec: got %b want 1111", bus.end_condition_lp_o);
        else n_pass++;
    endtask

    task automatic test_two_level;
        logic [7:0] e0 [6] = '{0, 1, 2, 0, 1, 2};
        logic [7:0] e1 [6] = '{0, 0, 0, 1, 1, 1};
        logic [3:0] ee [6] = '{4'b1100, 4'b1100, 4'b1101, 4'b1110, 4'b1110, 4'b1111};
        set_cfg(2, 0, 3, 1, 0, 2, 1, 1);
        run_seq(10, -1, -1, -1);
        for (int c = 0; c < 10; c++) begin
            n_total++;
            if ({v_rec[c], el_rec[c], done_rec[c], busy_rec[c]} !==
                {c >= 1 && c <= 6, c == 6, c >= 7, c >= 1 && c <= 6})
                $display("FAIL two_ctrl c%0d: got v/el/done/busy %b%b%b%b", c,
                         v_rec[c], el_rec[c], done_rec[c], busy_rec[c]);
            else n_pass++;
            if (c >= 1 && c <= 6) begin
                n_total++;
                if (lv_rec[c] !== {8'd0, 8'd0, e1[c-1], e0[c-1]} || ec_rec[c] !== ee[c-1])
                    $display("FAIL two_iv c%0d: got iv %h ec %b want %h%h ec %b", c,
                             lv_rec[c], ec_rec[c], e1[c-1], e0[c-1], ee[c-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_stride;
        logic [7:0] e0 [3] = '{1, 3, 5};
        logic [3:0] ee [3] = '{4'b1110, 4'b1110, 4'b1111};
        set_cfg(1, 1, 6, 2, 0, 0, 0, 1);
        run_seq(6, -1, -1, -1);
        for (int c = 0; c < 6; c++) begin
            n_total++;
            if ({v_rec[c], el_rec[c], done_rec[c]} !== {c >= 1 && c <= 3, c == 3, c >= 4})
                $display("FAIL stride_ctrl c%0d: got v/el/done %b%b%b", c,
                         v_rec[c], el_rec[c], done_rec[c]);
            else n_pass++;
            if (c >= 1 && c <= 3) begin
                n_total++;
                if (lv_rec[c] !== {24'h0, e0[c-1]} || ec_rec[c] !== ee[c-1])
                    $display("FAIL stride_iv c%0d: got iv %h ec %b want %h ec %b", c,
                             lv_rec[c], ec_rec[c], e0[c-1], ee[c-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_overflow;
        set_cfg(1, 100, 255, 200, 0, 0, 0, 1);
        run_seq(4, -1, -1, -1);
        n_total++;
        if ({v_rec[1], el_rec[1], lv_rec[1][0], ec_rec[1][0]} !== {1'b1, 1'b1, 8'd100, 1'b1})
            $display("FAIL ovf_issue: got v %b el %b iv %0d ec %b want 1 1 100 1",
                     v_rec[1], el_rec[1], lv_rec[1][0], ec_rec[1][0]);
        else n_pass++;
        n_total++;
        if ({v_rec[2], v_rec[3], done_rec[2]} !== 3'b001)
            $display("FAIL ovf_after: got v2 %b v3 %b done %b want 0 0 1",
                     v_rec[2], v_rec[3], done_rec[2]);
        else n_pass++;
    endtask

    task automatic test_ii;
        int nv;
        set_cfg(2, 0, 3, 1, 0, 2, 1, 3);
        run_seq(19, -1, -1, -1);
        for (int c = 0; c < 19; c++) begin
            n_total++;
            if (v_rec[c] !== (c >= 1 && c <= 16 && (c - 1) % 3 == 0) || el_rec[c] !== (c == 16))
                $display("FAIL ii3 c%0d: got v %b el %b", c, v_rec[c], el_rec[c]);
            else n_pass++;
        end
        n_total++;
        if (lv_rec[10] !== 32'h0000_0100 || done_rec[17] !== 1'b1)
            $display("FAIL ii3_iv: got iv@10 %h done@17 %b want 00000100 1",
                     lv_rec[10], done_rec[17]);
        else n_pass++;
        set_cfg(2, 0, 3, 1, 0, 2, 1, 0);
        run_seq(9, -1, -1, -1);
        nv = 0;
        for (int c = 0; c < 9; c++) nv += int'(v_rec[c]);
        n_total++;
        if (nv != 6 || el_rec[6] !== 1'b1 || v_rec[6] !== 1'b1)
            $display("FAIL ii0: got %0d valids el@6 %b want 6 1", nv, el_rec[6]);
        else n_pass++;
    endtask

    task automatic test_stall;
        logic       ev [8] = '{1, 1, 0, 0, 1, 1, 1, 1};
        logic [7:0] e0 [8] = '{0, 1, 2, 2, 2, 0, 1, 2};
        logic [7:0] e1 [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        set_cfg(2, 0, 3, 1, 0, 2, 1, 1);
        run_seq(10, 3, 4, -1);
        for (int c = 1; c <= 8; c++) begin
            n_total++;
            if (v_rec[c] !== ev[c-1] || lv_rec[c][1:0] !== {e1[c-1], e0[c-1]} ||
                el_rec[c] !== (c == 8))
                $display("FAIL stall c%0d: got v %b iv %h el %b want v %b iv %h%h", c,
                         v_rec[c], lv_rec[c][1:0], el_rec[c], ev[c-1], e1[c-1], e0[c-1]);
            else n_pass++;
        end
        n_total++;
        if (done_rec[9] !== 1'b1 || v_rec[9] !== 1'b0)
            $display("FAIL stall_done: got done %b v %b want 1 0", done_rec[9], v_rec[9]);
        else n_pass++;
    endtask

    task automatic test_empty;
        int nv;
        set_cfg(2, 0, 3, 1, 4, 4, 1, 1);
        run_seq(5, -1, -1, -1);
        nv = 0;
        for (int c = 0; c < 5; c++) nv += int'(v_rec[c]) + int'(busy_rec[c]);
        n_total++;
        if (nv != 0 || done_rec[0] !== 1'b0 || done_rec[1] !== 1'b1)
            $display("FAIL empty: got valid+busy %0d done0 %b done1 %b want 0 0 1",
                     nv, done_rec[0], done_rec[1]);
        else n_pass++;
    endtask

    task automatic test_abort;
        set_cfg(2, 0, 3, 1, 0, 2, 1, 1);
        run_seq(6, -1, -1, 3);
        n_total++;
        if ({v_rec[1], v_rec[2], v_rec[3], el_rec[3]} !== 4'b1100)
            $display("FAIL abort_gate: got v1 v2 v3 el3 %b%b%b%b want 1100",
                     v_rec[1], v_rec[2], v_rec[3], el_rec[3]);
        else n_pass++;
        n_total++;
        if (busy_rec[4] !== 1'b0 || done_rec[4] !== 1'b0 || lv_rec[4] !== 32'h0 ||
            ec_rec[4] !== 4'hF)
            $display("FAIL abort_idle: got busy %b done %b iv %h ec %b want 0 0 0 1111",
                     busy_rec[4], done_rec[4], lv_rec[4], ec_rec[4]);
        else n_pass++;
    endtask

    task automatic test_reset_midrun;
        set_cfg(2, 0, 3, 1, 0, 2, 1, 1);
        bus.start_i = 1'b1;
        repeat (3) begin @(posedge clk_i); #1; end
        n_total++;
        if (bus.busy_o !== 1'b1 || bus.loop_vars_o[0] !== 8'd2)
            $display("FAIL midrun_pre: got busy %b iv0 %0d want 1 2", bus.busy_o, bus.loop_vars_o[0]);
        else n_pass++;
        #2 rst_n_i = 1'b0;
        #1;
        n_total++;
        if ({bus.hwlp_valid_o, bus.busy_o, bus.done_o, bus.end_lp_o} !== 4'b0000 ||
            bus.loop_vars_o !== 32'h0 || bus.end_condition_lp_o !== 4'hF)
            $display("FAIL midrun_rst: got v/busy/done/el %b%b%b%b iv %h ec %b",
                     bus.hwlp_valid_o, bus.busy_o, bus.done_o, bus.end_lp_o,
                     bus.loop_vars_o, bus.end_condition_lp_o);
        else n_pass++;
        bus.start_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        rst_n_i     = 1'b0;
        bus.start_i = 1'b0;
        bus.stall_i = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk_i);
        #1;
        test_reset;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        test_two_level;
        test_stride;
        test_overflow;
        test_ii;
        test_stall;
        test_empty;
        test_abort;
        test_reset_midrun;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hwlp_iv_gen.md
# hwlp_iv_gen

Hardware-loop induction-variable generator for MAGE. It walks a configured loop nest of up to N_LP levels and emits one IV tuple per iteration. The tuple is paced by an initiation interval and carries per-level last-iteration flags and a nest-end flag. Its outputs drive the loop-variable, valid and end inputs of the IV delay register file. From these, the access units derive addresses.

## Interface
- N_LP, default mage_pkg::N_LP (4): loop nest depth; level 0 is innermost.
- NBIT_LP_IV, default mage_pkg::NBIT_LP_IV (8): IV width, unsigned.
- NBIT_II, default mage_pkg::NBIT_II (4): initiation-interval counter width.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  level enable; high = run; low = abort and return to idle.
- stall_i  in  1  freeze iteration progress.
- n_lp_i  in  $clog2(N_LP)+1  number of active levels, 1..N_LP.
- lp_start_i  in  N_LP x NBIT_LP_IV  per-level start value.
- lp_end_i  in  N_LP x NBIT_LP_IV  per-level exclusive bound.
- lp_stride_i  in  N_LP x NBIT_LP_IV  per-level stride; 0 is treated as 1.
- ii_i  in  NBIT_II  cycles between iterations; 0 is treated as 1.
- hwlp_valid_o  out  1  the current tuple is an issued iteration.
- loop_vars_o  out  N_LP x NBIT_LP_IV  current IVs.
- end_condition_lp_o  out  N_LP  per-level "IV is at its last value".
- end_lp_o  out  1  last iteration of the whole nest.
- busy_o  out  1  state is RUN.
- done_o  out  1  state is DONE.

## Operation
- States: IDLE, RUN, DONE. The state type is hwlp_state_t.
- IDLE, start_i=1: capture all config into registers and load iv[k]=lp_start_i[k].
  - If any active level has start>=end: go to DONE; no valid is ever issued.
  - Otherwise: go to RUN.
- Config inputs are ignored outside the IDLE->RUN transition.
- Inactive levels (k>=n_lp): IV held at 0, end_condition forced to 1.
- end_condition[k] = active(k) ? (iv[k]+stride[k] >= end[k]) : 1. The compare is done at NBIT_LP_IV+1 bits so there is no wrap.
- Issue condition in RUN: start_i & ~stall_i & (ii_cnt==0).
  - hwlp_valid_o = issue.
  - end_lp_o = issue & (&end_condition).
- On issue: the odometer advances.
  - Level 0 adds its stride.
  - A level with end_condition=1 reloads its start value and carries to the next level.
  - The carry propagates while end_condition=1.
- On issue, ii_cnt loads ii-1. While ii_cnt!=0 and no stall, it decrements. Stall freezes ii_cnt and all IVs.
- Issue with end_lp: go to DONE; IVs stay at their last values.
- DONE: done_o=1 until start_i=0, then go to IDLE.
- start_i=0 in any state: go to IDLE next cycle; IVs, ii_cnt and config registers are cleared. hwlp_valid_o and end_lp_o are gated by start_i and drop in the same cycle.
- Trip count of level k is ceil((end-start)/stride). Total issues = product over active levels.

## Timing
- Reset (async): state=IDLE, IVs=0, ii_cnt=0, config=0. All outputs are 0, except end_condition_lp_o, which is all ones from the forced inactive values.
- loop_vars_o and end_condition_lp_o are taken combinationally from registered IVs and config. hwlp_valid_o and end_lp_o also depend combinationally on start_i and stall_i.
- start_i rises in cycle 0 (IDLE) -> first valid in cycle 1. Iteration n (counting from 0, no stall) issues in cycle 1+n*ii.
- The last issue is in cycle t -> done_o=1 and busy_o=0 from cycle t+1.
- Empty nest: done_o=1 in cycle 1, zero valids.
- Stall and a last issue in the same cycle: the stall wins; nothing issues.

## Structure
- mage_pkg holds N_LP, NBIT_LP_IV, NBIT_II and hwlp_state_t.
- Sub-module hwlp_level_cnt, instantiated N_LP times. It holds one IV register.
  - Inputs: load, advance, carry_in, start, end, stride, active.
  - Outputs: iv, end_condition, carry_out.
- The top level holds the FSM, the ii counter and the output gating.

## Test plan
- Two-level nest, n_lp=2, ii=1; L0 0..3 step 1, L1 0..2 step 1.
  - Required: valids in cycles 1-6 with (iv0,iv1) = (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
  - Required: end_condition[0] high when iv0=2; end_lp high only in cycle 6; done_o from cycle 7.
- Stride and overflow, n_lp=1.
  - start 1, end 6, stride 2 -> IVs 1,3,5; end_condition on 5.
  - start 100, end 255, stride 200 -> a single iteration with end_lp=1 (9-bit compare).
- Pacing: ii=3 on the two-level case -> valids in cycles 1,4,7,...,16; ii=0 behaves as ii=1.
- Stall: stall_i high in cycles 3-4 of case 1 -> no valid and frozen IVs in those cycles; sequence resumes (2,0) in cycle 5, and the last valid lands in cycle 8.
- Empty and abort cases:
  - L1 start=end=4 -> zero valids and done_o in cycle 1.
  - start_i dropped in cycle 3 -> valid=0 that cycle, IDLE next, IVs 0.
  - rst_n_i asserted mid-run -> immediate reset values.
